// File: rtl/led_pkg.sv
// Shared types and helpers for the LED bank arbiter and its sibling arbiters.
package led_pkg;

    // Width of the board LED bank.
    localparam int LED_BITS = 5;

    // Widest requester vector any arbiter built on this package supports.
    localparam int MAX_NREQ = 8;

    // Arbiter FSM states; 2'b11 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        GUARD = 2'b10
    } state_t;

    // One-hot vector with bit `index` set; callers slice down to their NREQ.
    function automatic logic [MAX_NREQ-1:0] onehot(input int unsigned index);
        onehot = MAX_NREQ'(1) << index;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first requester after `last`, with wrap.
module rr_pick #(
    parameter  int NREQ = 3,
    localparam int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last,
    output logic [IDXW-1:0] winner,
    output logic            any_req
);

    int idx;

    // Scan (last+1) mod NREQ upward; the first hit wins, so `last` ranks lowest.
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise the tool infers a latch to hold it.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!any_req && req[IDXW'(idx)]) begin
                any_req = 1'b1;
                winner  = IDXW'(idx);
            end
        end
    end

endmodule

// File: rtl/led_bank_arbiter.sv
// Round-robin owner of the board LED bank, with a bounded hold period per
// grant and a blank guard gap between successive owners. All outputs are
// registered so nothing combinational reaches the pins from req/pat.
module led_bank_arbiter
    import led_pkg::*;
#(
    parameter int NREQ      = 3,
    parameter int LOG2HOLD  = 21,
    parameter int GUARD_CYC = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [LED_BITS*NREQ-1:0] pat,
    output logic [LED_BITS-1:0]      led,
    output logic [NREQ-1:0]          gnt,
    output logic                     busy
);

    localparam int IDXW = $clog2(NREQ);
    localparam int GW   = $clog2(GUARD_CYC + 1);

    state_t              state, state_nxt;
    logic [LOG2HOLD-1:0] hold_cnt, hold_nxt;
    logic [GW-1:0]       guard_cnt, guard_nxt;

    // `last` is the most recent winner; while in GRANT it is also the owner.
    logic [IDXW-1:0]     last, last_nxt;

    logic [LED_BITS-1:0] led_nxt;
    logic [NREQ-1:0]     gnt_nxt;
    logic                busy_nxt;

    logic [IDXW-1:0]     winner;
    logic                any_req;
    logic [MAX_NREQ-1:0] win_oh, own_oh;
    logic [NREQ-1:0]     others;
    logic                hold_max;
    logic                guard_done;

    logic [LED_BITS-1:0] pat_arr [NREQ];

    // Unpack the flat pattern bus so a source can be selected by index.
    for (genvar i = 0; i < NREQ; i++) begin : g_pat
        assign pat_arr[i] = pat[LED_BITS*i +: LED_BITS];
    end

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req     (req),
        .last    (last),
        .winner  (winner),
        .any_req (any_req)
    );

    assign win_oh     = onehot(int'(winner));
    assign own_oh     = onehot(int'(last));
    assign others     = req & ~own_oh[NREQ-1:0];
    assign hold_max   = &hold_cnt;
    assign guard_done = (guard_cnt == GW'(GUARD_CYC - 1));

    // Next-state, counter and output-register values; LEDs and grant are blank
    // unless a cycle of ownership is being entered or continued.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        guard_nxt = guard_cnt;
        last_nxt  = last;
        led_nxt   = '0;
        gnt_nxt   = '0;

        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = GRANT;
                    gnt_nxt   = win_oh[NREQ-1:0];
                    led_nxt   = pat_arr[winner];
                    hold_nxt  = '0;
                    last_nxt  = winner;
                end
            end

            GRANT: begin
                // Release and preemption share one exit, so a coincident
                // release at hold expiry still enters GUARD exactly once.
                if (!req[last] || (hold_max && (|others))) begin
                    state_nxt = GUARD;
                    guard_nxt = '0;
                end else begin
                    // At expiry with no competitor the counter simply wraps.
                    gnt_nxt  = own_oh[NREQ-1:0];
                    led_nxt  = pat_arr[last];
                    hold_nxt = hold_cnt + LOG2HOLD'(1);
                end
            end

            GUARD: begin
                // req is deliberately ignored; arbitration resumes from IDLE.
                if (guard_done) begin
                    state_nxt = IDLE;
                end else begin
                    guard_nxt = guard_cnt + GW'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State, counters and registered outputs; reset makes requester 0 first.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    // NOTE: every register here is control state and gets an explicit reset
    // value; there is no storage array that could be left unreset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            guard_cnt <= '0;
            last      <= IDXW'(NREQ - 1);
            led       <= '0;
            gnt       <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_nxt;
            guard_cnt <= guard_nxt;
            last      <= last_nxt;
            led       <= led_nxt;
            gnt       <= gnt_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Randomised bench for led_bank_arbiter against an ownership-level model.
module tb_led_bank_arbiter;

    localparam int NREQ      = 3;
    localparam int LOG2HOLD  = 4;
    localparam int GUARD_CYC = 2;
    localparam int HOLD      = 1 << LOG2HOLD;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [5*NREQ-1:0] pat;
    logic [4:0]        led;
    logic [NREQ-1:0]   gnt;
    logic              busy;

    int tests = 0;
    int fails = 0;

    // Model: who owns the bank, how many cycles of the current hold period
    // they have been given (1..HOLD), and how many blank guard cycles remain.
    int         m_owner;
    int         m_held;
    int         m_blank;
    int         m_last;
    logic [4:0] m_led;

    led_bank_arbiter #(
        .NREQ      (NREQ),
        .LOG2HOLD  (LOG2HOLD),
        .GUARD_CYC (GUARD_CYC)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .pat  (pat),
        .led  (led),
        .gnt  (gnt),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] pat_of(input int i);
        return pat[5*i +: 5];
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_blank = 0;
        m_last  = NREQ - 1;
        m_led   = '0;
    endtask

    // Advance the model by one clock edge using the pre-edge req/pat.
    task automatic model_step();
        logic [NREQ-1:0] mask;
        bit released, expire, rivals;
        if (m_owner >= 0) begin
            mask           = '0;
            mask[m_owner]  = 1'b1;
            released       = !req[m_owner];
            rivals         = (req & ~mask) != '0;
            expire         = (m_held == HOLD);
            if (released || (expire && rivals)) begin
                m_owner = -1;
                m_blank = GUARD_CYC;
                m_led   = '0;
            end else begin
                m_held = expire ? 1 : m_held + 1;
                m_led  = pat_of(m_owner);
            end
        end else if (m_blank > 0) begin
            m_blank--;
            m_led = '0;
        end else begin
            for (int k = 1; k <= NREQ; k++) begin
                if (m_owner < 0 && req[(m_last + k) % NREQ])
                    m_owner = (m_last + k) % NREQ;
            end
            if (m_owner >= 0) begin
                m_last = m_owner;
                m_held = 1;
                m_led  = pat_of(m_owner);
            end else begin
                m_led = '0;
            end
        end
    endtask

    task automatic check_outputs();
        logic [NREQ-1:0] eg;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        check("led", 32'(led), 32'(m_led));
        check("gnt", 32'(gnt), 32'(eg));
        check("busy", 32'(busy), 32'((m_owner >= 0) || (m_blank > 0)));
    endtask

    // One clock: model follows the edge, outputs compared at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    // Assert reset between edges; outputs must clear before the next edge.
    task automatic mid_cycle_reset();
        @(posedge clk);
        model_step();
        #2 rst = 1'b1;
        model_reset();
        #1 check_outputs();
        @(negedge clk);
        rst = 1'b0;
        check_outputs();
    endtask

    task automatic run(input int n, input bit rand_pat);
        for (int c = 0; c < n; c++) begin
            if (rand_pat) pat = 15'($urandom);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        pat = '0;
        model_reset();
        #12 check_outputs();
        @(negedge clk);
        rst = 1'b0;

        // Idle with no requests.
        run(50, 1'b1);

        // Single owner: hold wraps repeatedly with no preemption.
        req = 3'b010;
        pat = 15'b00000_10101_00000;
        run(20, 1'b0);
        pat = 15'b11111_01010_11111;
        run(40, 1'b0);

        // Early release, then idle.
        req = 3'b000;
        run(6, 1'b1);

        // Round-robin from reset with all sources requesting.
        mid_cycle_reset();
        req = 3'b111;
        run(120, 1'b1);

        // Reset while source 2 owns the bank; source 0 must win afterwards.
        for (int c = 0; c < 80 && m_owner != 2; c++) tick();
        check("owner2_reached", 32'(m_owner == 2), 32'(1));
        mid_cycle_reset();
        run(30, 1'b1);

        // Random requests, steering hold expiry into release/preempt coincidences.
        for (int c = 0; c < 1500; c++) begin
            pat = 15'($urandom);
            if (m_owner >= 0 && m_held == HOLD) begin
                req[(m_owner + 1 + $urandom_range(0, NREQ - 2)) % NREQ] = 1'b1;
                req[m_owner] = 1'($urandom_range(0, 1));
            end else if ($urandom_range(0, 5) == 0) begin
                req[$urandom_range(0, NREQ - 1)] ^= 1'b1;
            end
            if ($urandom_range(0, 299) == 0) mid_cycle_reset();
            else tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
